// File: rtl/pipeline_hazard_unit_pkg.sv
// Shared constants and types for the ID-stage hazard unit:
// register width, forward-select encoding, mult/div FSM states.
package pipeline_hazard_unit_pkg;
  localparam int REG_ADDR_W   = 5;
  localparam int FWD_SEL_NONE = 0;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_BUSY = 2'd1,
    MD_DONE = 2'd2
  } md_state_e;
endpackage

// File: rtl/pipeline_hazard_unit_if.sv
// ID-side hazard bundle: operand/producer info in,
// forward selects, stall and mult/div status out.
interface pipeline_hazard_unit_if #(
  parameter int REG_ADDR_W = 5,
  parameter int NUM_SRC    = 2,
  parameter int FWD_STAGES = 3,
  parameter int SEL_W      = $clog2(FWD_STAGES+1)
);
  logic                             id_valid;
  logic [NUM_SRC*REG_ADDR_W-1:0]    id_src_addr;
  logic [NUM_SRC-1:0]               id_src_used;
  logic                             id_is_md;
  logic                             id_reads_hilo;
  logic [FWD_STAGES-1:0]            stg_reg_write;
  logic [FWD_STAGES*REG_ADDR_W-1:0] stg_dst_addr;
  logic [FWD_STAGES-1:0]            stg_data_ready;
  logic [NUM_SRC*SEL_W-1:0]         fwd_sel;
  logic                             stall;
  logic                             md_start;
  logic                             md_busy;
  logic                             md_done;
  logic [15:0]                      stall_count;

  modport master (
    output id_valid, id_src_addr, id_src_used,
    output id_is_md, id_reads_hilo,
    output stg_reg_write, stg_dst_addr, stg_data_ready,
    input  fwd_sel, stall, md_start, md_busy,
    input  md_done, stall_count
  );

  modport slave (
    input  id_valid, id_src_addr, id_src_used,
    input  id_is_md, id_reads_hilo,
    input  stg_reg_write, stg_dst_addr, stg_data_ready,
    output fwd_sel, stall, md_start, md_busy,
    output md_done, stall_count
  );
endinterface

// File: rtl/pipeline_hazard_unit_fwd_operand_match.sv
// Per-operand forward match: youngest producing stage wins,
// and flags when that stage's result is not yet available.
module fwd_operand_match
  import pipeline_hazard_unit_pkg::*;
#(
  parameter int REG_ADDR_W = 5,
  parameter int FWD_STAGES = 3,
  parameter int SEL_W      = $clog2(FWD_STAGES+1)
) (
  input  logic [REG_ADDR_W-1:0]            src_addr,
  input  logic                             src_used,
  input  logic [FWD_STAGES-1:0]            stg_reg_write,
  input  logic [FWD_STAGES*REG_ADDR_W-1:0] stg_dst_addr,
  input  logic [FWD_STAGES-1:0]            stg_data_ready,
  output logic [SEL_W-1:0]                 sel,
  output logic                             not_ready
);
  logic                  found;
  logic [REG_ADDR_W-1:0] dst;

  always_comb begin
    sel       = SEL_W'(FWD_SEL_NONE);
    not_ready = 1'b0;
    found     = 1'b0;
    dst       = '0;
    for (int k = 0; k < FWD_STAGES; k++) begin
      dst = stg_dst_addr[k*REG_ADDR_W +: REG_ADDR_W];
      if (!found && src_used && stg_reg_write[k] &&
          dst != '0 && dst == src_addr) begin
        sel       = SEL_W'(k + 1);
        not_ready = !stg_data_ready[k];
        found     = 1'b1;
      end
    end
  end
endmodule

// File: rtl/pipeline_hazard_unit.sv
// ID-stage hazard unit: operand forwarding, load-use stall,
// mult/div busy tracking and a saturating stall counter.
module pipeline_hazard_unit
  import pipeline_hazard_unit_pkg::*;
#(
  parameter int REG_ADDR_W = pipeline_hazard_unit_pkg::REG_ADDR_W,
  parameter int NUM_SRC    = 2,
  parameter int FWD_STAGES = 3,
  parameter int MD_LATENCY = 32,
  parameter int SEL_W      = $clog2(FWD_STAGES+1)
) (
  input  logic clk,
  input  logic rst,
  pipeline_hazard_unit_if.slave hz
);
  localparam int CNT_W = $clog2(MD_LATENCY);

  md_state_e          state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [15:0]        sc_q, sc_d;
  logic [NUM_SRC-1:0] nrdy;
  logic               dstall, mstall, start;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    fwd_operand_match #(
      .REG_ADDR_W (REG_ADDR_W),
      .FWD_STAGES (FWD_STAGES),
      .SEL_W      (SEL_W)
    ) u_match (
      .src_addr       (hz.id_src_addr[i*REG_ADDR_W +: REG_ADDR_W]),
      .src_used       (hz.id_src_used[i]),
      .stg_reg_write  (hz.stg_reg_write),
      .stg_dst_addr   (hz.stg_dst_addr),
      .stg_data_ready (hz.stg_data_ready),
      .sel            (hz.fwd_sel[i*SEL_W +: SEL_W]),
      .not_ready      (nrdy[i])
    );
  end

  assign dstall = hz.id_valid && |nrdy;
  assign start  = hz.id_valid && hz.id_is_md && !dstall &&
                  state_q != MD_BUSY;
  // mfhi/mflo in DONE read the fresh result, so only BUSY blocks
  assign mstall = hz.id_valid &&
                  (hz.id_is_md || hz.id_reads_hilo) &&
                  state_q == MD_BUSY;

  assign hz.stall       = dstall || mstall;
  assign hz.md_start    = start;
  assign hz.md_busy     = state_q == MD_BUSY;
  assign hz.md_done     = state_q == MD_DONE;
  assign hz.stall_count = sc_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      MD_IDLE: begin
        if (start) begin
          state_d = MD_BUSY;
          cnt_d   = CNT_W'(MD_LATENCY - 2);
        end
      end
      MD_BUSY: begin
        if (cnt_q == '0) state_d = MD_DONE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      MD_DONE: begin
        if (start) begin
          state_d = MD_BUSY;
          cnt_d   = CNT_W'(MD_LATENCY - 2);
        end else begin
          state_d = MD_IDLE;
        end
      end
      default: state_d = MD_IDLE;
    endcase
  end

  always_comb begin
    sc_d = sc_q;
    if (hz.stall && sc_q != 16'hFFFF) sc_d = sc_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= MD_IDLE;
      cnt_q   <= '0;
      sc_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sc_q    <= sc_d;
    end
  end
endmodule

// File: tb/tb_pipeline_hazard_unit.sv
// Scoreboard bench for pipeline_hazard_unit: directed vectors push
// expected outputs; a negedge monitor pops and compares.
module tb_pipeline_hazard_unit;
  localparam int RW = 5;
  localparam int NS = 2;
  localparam int FS = 3;
  localparam int SW = 2;
  localparam int ML = 32;

  typedef struct {
    string       nm;
    logic [3:0]  sel;
    logic        stall;
    logic        start;
    logic        busy;
    logic        done;
    logic [15:0] sc;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  exp_t q[$];
  int   nchk = 0;
  int   nerr = 0;
  logic [15:0] exp_sc = '0;

  always #5 clk = ~clk;

  pipeline_hazard_unit_if #(
    .REG_ADDR_W(RW), .NUM_SRC(NS), .FWD_STAGES(FS), .SEL_W(SW)
  ) hz ();

  pipeline_hazard_unit #(
    .REG_ADDR_W(RW), .NUM_SRC(NS), .FWD_STAGES(FS),
    .MD_LATENCY(ML), .SEL_W(SW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .hz  (hz)
  );

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      nchk++;
      if (hz.fwd_sel !== e.sel || hz.stall !== e.stall ||
          hz.md_start !== e.start || hz.md_busy !== e.busy ||
          hz.md_done !== e.done || hz.stall_count !== e.sc) begin
        nerr++;
        $display("FAIL %s: got sel=%h stall=%b start=%b busy=%b done=%b cnt=%h, want sel=%h stall=%b start=%b busy=%b done=%b cnt=%h",
                 e.nm, hz.fwd_sel, hz.stall, hz.md_start, hz.md_busy,
                 hz.md_done, hz.stall_count, e.sel, e.stall, e.start,
                 e.busy, e.done, e.sc);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic idle_in();
    hz.id_valid       = 1'b0;
    hz.id_src_addr    = '0;
    hz.id_src_used    = '0;
    hz.id_is_md       = 1'b0;
    hz.id_reads_hilo  = 1'b0;
    hz.stg_reg_write  = '0;
    hz.stg_dst_addr   = '0;
    hz.stg_data_ready = '1;
  endtask

  task automatic set_src(input int i, input logic [RW-1:0] a,
                         input logic u);
    hz.id_src_addr[i*RW +: RW] = a;
    hz.id_src_used[i]          = u;
  endtask

  task automatic set_stg(input int k, input logic we,
                         input logic [RW-1:0] a, input logic rdy);
    hz.stg_reg_write[k]         = we;
    hz.stg_dst_addr[k*RW +: RW] = a;
    hz.stg_data_ready[k]        = rdy;
  endtask

  task automatic cyc(input string nm, input bit chk,
                     input logic [1:0] s0, input logic [1:0] s1,
                     input logic st, input logic sta,
                     input logic bsy, input logic dn);
    exp_t e;
    if (chk) begin
      e.nm = nm; e.sel = {s1, s0}; e.stall = st;
      e.start = sta; e.busy = bsy; e.done = dn; e.sc = exp_sc;
      q.push_back(e);
    end
    @(negedge clk);
    @(posedge clk);
    if (rst) exp_sc = '0;
    else if (st && exp_sc != 16'hFFFF) exp_sc = exp_sc + 16'd1;
    #1;
  endtask

  initial begin
    rst = 1'b1;
    idle_in();
    @(posedge clk); #1;
    cyc("reset", 1, 0, 0, 0, 0, 0, 0);
    rst = 1'b0;

    // youngest stage wins
    hz.id_valid = 1'b1;
    set_src(0, 5, 1);
    set_stg(0, 1, 5, 1); set_stg(1, 1, 5, 1);
    cyc("fwd_ex_prio", 1, 1, 0, 0, 0, 0, 0);
    set_stg(0, 0, 5, 1);
    cyc("fwd_mem", 1, 2, 0, 0, 0, 0, 0);
    set_src(0, 5, 0);
    cyc("unused_src", 1, 0, 0, 0, 0, 0, 0);
    set_src(0, 5, 1); set_stg(1, 1, 5, 0);
    cyc("mem_not_ready", 1, 2, 0, 1, 0, 0, 0);
    hz.id_valid = 1'b0;
    cyc("not_ready_no_valid", 1, 2, 0, 0, 0, 0, 0);

    // load-use stall
    idle_in(); hz.id_valid = 1'b1;
    set_src(1, 7, 1); set_stg(0, 1, 7, 0);
    for (int i = 0; i < 3; i++) cyc("load_use", 1, 0, 1, 1, 0, 0, 0);

    // r0 never forwards; WB-only match
    idle_in(); hz.id_valid = 1'b1;
    set_src(0, 0, 1); set_src(1, 9, 1);
    set_stg(0, 1, 0, 1); set_stg(2, 1, 9, 1);
    cyc("r0_and_wb", 1, 0, 3, 0, 0, 0, 0);

    // md op blocked by a data stall does not start
    idle_in(); hz.id_valid = 1'b1; hz.id_is_md = 1'b1;
    set_src(0, 4, 1); set_stg(0, 1, 4, 0);
    cyc("md_dstall", 1, 1, 0, 1, 0, 0, 0);

    // md op then mfhi through BUSY and DONE
    idle_in(); hz.id_valid = 1'b1; hz.id_is_md = 1'b1;
    cyc("md_start", 1, 0, 0, 0, 1, 0, 0);
    hz.id_is_md = 1'b0; hz.id_reads_hilo = 1'b1;
    for (int i = 0; i < ML - 1; i++)
      cyc("mfhi_busy", 1, 0, 0, 1, 0, 1, 0);
    cyc("mfhi_done", 1, 0, 0, 0, 0, 0, 1);
    idle_in();
    cyc("md_idle", 1, 0, 0, 0, 0, 0, 0);

    // second md op held in ID restarts in DONE
    hz.id_valid = 1'b1; hz.id_is_md = 1'b1;
    cyc("md2_start", 1, 0, 0, 0, 1, 0, 0);
    for (int i = 0; i < ML - 1; i++)
      cyc("md2_hold", 1, 0, 0, 1, 0, 1, 0);
    cyc("md2_b2b", 1, 0, 0, 0, 1, 0, 1);
    hz.id_valid = 1'b0;
    for (int i = 0; i < ML - 1; i++)
      cyc("md3_busy", 1, 0, 0, 0, 0, 1, 0);
    cyc("md3_done", 1, 0, 0, 0, 0, 0, 1);
    cyc("md3_idle", 1, 0, 0, 0, 0, 0, 0);

    // reset mid-BUSY
    hz.id_valid = 1'b1; hz.id_is_md = 1'b1;
    cyc("md4_start", 1, 0, 0, 0, 1, 0, 0);
    hz.id_valid = 1'b0;
    cyc("md4_busy", 1, 0, 0, 0, 0, 1, 0);
    cyc("md4_busy", 1, 0, 0, 0, 0, 1, 0);
    rst = 1'b1;
    cyc("rst_in_busy", 1, 0, 0, 0, 0, 1, 0);
    rst = 1'b0;
    for (int i = 0; i < ML + 3; i++)
      cyc("after_rst", 1, 0, 0, 0, 0, 0, 0);

    // saturation
    idle_in(); hz.id_valid = 1'b1;
    set_src(1, 7, 1); set_stg(0, 1, 7, 0);
    for (int i = 0; i < 70000; i++)
      cyc("saturate",
          (i == 0 || i == 65534 || i == 65535 || i == 65536 ||
           i >= 69998), 0, 1, 1, 0, 0, 0);

    idle_in();
    @(negedge clk); #1;
    if (q.size() != 0) begin
      nerr++;
      $display("FAIL drain: %0d pending, want 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
